// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line in, decoded byte and status pulses out
interface uart_receiver_if;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_frame_err;
  logic       rx_busy;
  modport master (output rx, input rx_byte, rx_done, rx_frame_err, rx_busy);
  modport slave (input rx, output rx_byte, rx_done, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, 16x oversampling, mid-bit sampling
module uart_receiver #(
  parameter int F_CLK    = 10_000_000,
  parameter int BAUDRATE = 9600
) (
  input logic            clk,
  input logic            rst,
  uart_receiver_if.slave bus
);
  localparam int SAMPLE_PERIOD = F_CLK / (16 * BAUDRATE);
  localparam int TW = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_HIGH = 3'd4;
  logic [1:0]    sync_q, sync_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    ocnt_q, ocnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rxs, tick;
  assign rxs = sync_q[1];
  assign tick = tcnt_q == TW'(SAMPLE_PERIOD - 1);
  assign bus.rx_byte = byte_q;
  assign bus.rx_done = done_q;
  assign bus.rx_frame_err = err_q;
  assign bus.rx_busy = state_q != IDLE;
  always_comb begin
    sync_d = {sync_q[0], bus.rx};
    // holding the tick counter at zero in IDLE aligns sample phase to the start edge
    tcnt_d = (state_q == IDLE || tick) ? '0 : tcnt_q + TW'(1);
    ocnt_d = tick ? ocnt_q + 4'd1 : ocnt_q;
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    byte_d = byte_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        ocnt_d = '0;
        state_d = rxs ? IDLE : START;
      end
      START: if (tick && ocnt_q == 4'd7) begin
        ocnt_d = '0;
        bit_d = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (tick && ocnt_q == 4'd15) begin
        shift_d = {rxs, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick && ocnt_q == 4'd15) begin
        byte_d = rxs ? shift_q : byte_q;
        done_d = rxs;
        err_d = !rxs;
        state_d = rxs ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: state_d = rxs ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      tcnt_q  <= '0;
      ocnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      ocnt_q  <= ocnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule
